// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_ctrl
// Brief    : Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; optional
//            single-cycle multiply when MULDIV_FAST_MULT_EN is defined.
// Revision : 1.0
// ============================================================================
module muldiv_ctrl #(
   parameter int NB_DATA = 32,
   parameter int NB_CNT  = 6
) (
   input  logic               clock_i,
   input  logic               reset_n_i,
   input  logic               start_i,
   input  logic [1:0]         op_i,
   input  logic [NB_DATA-1:0] data_ra_i,
   input  logic [NB_DATA-1:0] data_rb_i,
   input  logic               wr_hi_i,
   input  logic               wr_lo_i,
   input  logic               rd_hilo_i,
   output logic               busy_o,
   output logic               stall_o,
   output logic               done_o,
   output logic [NB_DATA-1:0] hi_o,
   output logic [NB_DATA-1:0] lo_o
);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_PREP = 2'd1;
   localparam logic [1:0] c_CALC = 2'd2;
   localparam logic [1:0] c_FIX  = 2'd3;

   localparam logic [NB_CNT-1:0] c_ITER = NB_CNT'(NB_DATA);
   localparam logic [NB_CNT-1:0] c_ONE  = NB_CNT'(1);

   logic [1:0]           r_state;
   logic [1:0]           w_next;
   logic                 w_busy;

   logic [1:0]           r_op;
   logic [NB_DATA-1:0]   r_ra;
   logic [NB_DATA-1:0]   r_rb;
   logic [NB_DATA-1:0]   r_opb;
   logic [2*NB_DATA-1:0] r_acc;
   logic [NB_CNT-1:0]    r_cnt;
   logic                 r_neg_q;
   logic                 r_neg_r;
   logic                 r_div0;
   logic                 r_done;
   logic [NB_DATA-1:0]   r_hi;
   logic [NB_DATA-1:0]   r_lo;

   logic                 w_is_div;
   logic                 w_is_signed;
   logic [NB_DATA-1:0]   w_abs_a;
   logic [NB_DATA-1:0]   w_abs_b;
   logic [NB_DATA:0]     w_shift;
   logic [NB_DATA:0]     w_alu_a;
   logic [NB_DATA:0]     w_alu_b;
   logic [NB_DATA:0]     w_alu;
   logic                 w_fit;
   logic [2*NB_DATA-1:0] w_acc_next;
   logic [2*NB_DATA-1:0] w_prod;
   logic [NB_DATA-1:0]   w_quo;
   logic [NB_DATA-1:0]   w_rem;
   logic [NB_DATA-1:0]   w_res_hi;
   logic [NB_DATA-1:0]   w_res_lo;

   assign w_is_div    = r_op[1];
   assign w_is_signed = ~r_op[0];
   assign w_abs_a     = (w_is_signed && r_ra[NB_DATA-1]) ? -r_ra : r_ra;
   assign w_abs_b     = (w_is_signed && r_rb[NB_DATA-1]) ? -r_rb : r_rb;

   // One adder serves both ops: add multiplicand for multiply, subtract divisor for divide.
   assign w_shift = {r_acc[2*NB_DATA-1:NB_DATA], r_acc[NB_DATA-1]};
   assign w_alu_a = w_is_div ? w_shift : {1'b0, r_acc[2*NB_DATA-1:NB_DATA]};
   assign w_alu_b = w_is_div ? ~{1'b0, r_opb}
                             : (r_acc[0] ? {1'b0, r_opb} : '0);
   assign w_alu   = w_alu_a + w_alu_b + {{NB_DATA{1'b0}}, w_is_div};
   assign w_fit   = ~w_alu[NB_DATA];

   always_comb begin
      w_acc_next = r_acc;
      if (w_is_div) begin
         w_acc_next = {(w_fit ? w_alu[NB_DATA-1:0] : w_shift[NB_DATA-1:0]),
                       r_acc[NB_DATA-2:0], w_fit};
      end else begin
         w_acc_next = {w_alu, r_acc[NB_DATA-1:1]};
      end
   end

`ifdef MULDIV_FAST_MULT_EN
   logic [2*NB_DATA-1:0] w_ext_a;
   logic [2*NB_DATA-1:0] w_ext_b;
   assign w_ext_a = {{NB_DATA{w_is_signed & r_ra[NB_DATA-1]}}, r_ra};
   assign w_ext_b = {{NB_DATA{w_is_signed & r_rb[NB_DATA-1]}}, r_rb};
   assign w_prod  = w_ext_a * w_ext_b;
`else
   assign w_prod  = r_neg_q ? -r_acc : r_acc;
`endif

   assign w_quo = r_acc[NB_DATA-1:0];
   assign w_rem = r_acc[2*NB_DATA-1:NB_DATA];

   always_comb begin
      w_res_hi = w_prod[2*NB_DATA-1:NB_DATA];
      w_res_lo = w_prod[NB_DATA-1:0];
      if (w_is_div) begin
         if (r_div0) begin
            w_res_hi = r_ra;
            w_res_lo = '1;
         end else begin
            w_res_hi = r_neg_r ? -w_rem : w_rem;
            w_res_lo = r_neg_q ? -w_quo : w_quo;
         end
      end
   end

   // State register
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         c_IDLE: begin
            if (start_i) begin
`ifdef MULDIV_FAST_MULT_EN
               w_next = op_i[1] ? c_PREP : c_FIX;
`else
               w_next = c_PREP;
`endif
            end
         end
         c_PREP:  w_next = c_CALC;
         c_CALC:  w_next = (r_cnt == c_ONE) ? c_FIX : c_CALC;
         c_FIX:   w_next = c_IDLE;
         default: w_next = c_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      w_busy = (r_state != c_IDLE);
   end

   assign busy_o  = w_busy;
   assign stall_o = w_busy & (start_i | rd_hilo_i | wr_hi_i | wr_lo_i);
   assign done_o  = r_done;
   assign hi_o    = r_hi;
   assign lo_o    = r_lo;

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_op    <= '0;
         r_ra    <= '0;
         r_rb    <= '0;
         r_opb   <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_div0  <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (start_i) begin
                  r_op <= op_i;
                  r_ra <= data_ra_i;
                  r_rb <= data_rb_i;
               end
            end
            c_PREP: begin
               r_opb   <= w_abs_b;
               r_acc   <= {{NB_DATA{1'b0}}, w_abs_a};
               r_cnt   <= c_ITER;
               r_neg_q <= w_is_signed & (r_ra[NB_DATA-1] ^ r_rb[NB_DATA-1]);
               r_neg_r <= w_is_signed & r_ra[NB_DATA-1];
               r_div0  <= (r_rb == '0);
            end
            c_CALC: begin
               r_acc <= w_acc_next;
               r_cnt <= r_cnt - c_ONE;
            end
            default: ;
         endcase
      end
   end

   // HI/LO change only on FIX or an idle-state MTHI/MTLO; start pre-empts the write.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_hi   <= '0;
         r_lo   <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= (r_state == c_FIX);
         if (r_state == c_FIX) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
         end else if (r_state == c_IDLE && !start_i) begin
            if (wr_hi_i) r_hi <= data_ra_i;
            if (wr_lo_i) r_lo <= data_ra_i;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_ctrl
// Brief    : Directed scoreboard bench for muldiv_ctrl (default iterative build).
// Revision : 1.0
// ============================================================================
module tb_muldiv_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] ra;
   logic [31:0] rb;
   logic        wr_hi;
   logic        wr_lo;
   logic        rd_hilo;
   logic        busy;
   logic        stall;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks = 0;
   int n_errors = 0;
   logic [63:0] sb[$];

   muldiv_ctrl #(.NB_DATA(32), .NB_CNT(6)) u_dut (
      .clock_i   (clk),
      .reset_n_i (rst_n),
      .start_i   (start),
      .op_i      (op),
      .data_ra_i (ra),
      .data_rb_i (rb),
      .wr_hi_i   (wr_hi),
      .wr_lo_i   (wr_lo),
      .rd_hilo_i (rd_hilo),
      .busy_o    (busy),
      .stall_o   (stall),
      .done_o    (done),
      .hi_o      (hi),
      .lo_o      (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issues one operation, measures busy/stall cycles, and compares HI/LO on done.
   task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp,
                        input bit hold_rd, input bit mid_wr);
      int  busy_cnt;
      int  stall_cnt;
      bit  seen;
      logic [31:0] lo_before;
      logic [63:0] e;
      busy_cnt  = 0;
      stall_cnt = 0;
      seen      = 0;
      sb.push_back(exp);
      @(negedge clk);
      lo_before = lo;
      start = 1'b1; op = o; ra = a; rb = b; rd_hilo = hold_rd;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            check({tag, "_done_busy"}, {63'd0, busy}, 64'd0);
            check({tag, "_done_stall"}, {63'd0, stall}, 64'd0);
         end else begin
            if (busy)  busy_cnt++;
            if (stall) stall_cnt++;
            if (mid_wr && i == 5) begin
               wr_lo = 1'b1;
               ra    = 32'hDEAD_BEEF;
            end
            if (mid_wr && i == 7) begin
               check({tag, "_midop_stall"}, {63'd0, stall}, 64'd1);
               check({tag, "_midop_lo"}, {32'd0, lo}, {32'd0, lo_before});
               wr_lo = 1'b0;
            end
         end
      end
      rd_hilo = 1'b0;
      check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd34);
      if (hold_rd) check({tag, "_stall_cycles"}, 64'(stall_cnt), 64'd34);
      if (!seen) begin
         check({tag, "_timeout"}, 64'd0, 64'd1);
         void'(sb.pop_front());
      end else begin
         e = sb.pop_front();
         check({tag, "_hilo"}, {hi, lo}, e);
         @(negedge clk);
         check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; op = 2'b00; ra = '0; rb = '0;
      wr_hi = 1'b0; wr_lo = 1'b0; rd_hilo = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy",  {63'd0, busy},  64'd0);
      check("rst_done",  {63'd0, done},  64'd0);
      check("rst_stall", {63'd0, stall}, 64'd0);
      check("rst_hilo",  {hi, lo},       64'd0);
      rst_n = 1'b1;

      do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, 0);
      do_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB, 0, 0);
      do_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 1, 0);
      do_op("divu",      2'b11, 32'd100,       32'd7,         64'h0000_0002_0000_000E, 0, 1);
      do_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0, 0);
      do_op("divu_zero", 2'b11, 32'h0000_1234, 32'd0,         64'h0000_1234_FFFF_FFFF, 0, 0);
      do_op("div_zero",  2'b10, 32'hFFFF_FFFB, 32'd0,         64'hFFFF_FFFB_FFFF_FFFF, 0, 0);

      // MTHI in IDLE
      @(negedge clk);
      wr_hi = 1'b1; ra = 32'hCAFE_BABE;
      check("mthi_nostall", {63'd0, stall}, 64'd0);
      @(negedge clk);
      wr_hi = 1'b0;
      check("mthi_hilo", {hi, lo}, 64'hCAFE_BABE_FFFF_FFFF);

      // Asynchronous reset in the middle of a DIV
      @(negedge clk);
      start = 1'b1; op = 2'b10; ra = 32'd1000; rb = 32'd3;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(negedge clk);
      check("pre_rst_busy", {63'd0, busy}, 64'd1);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_busy", {63'd0, busy}, 64'd0);
      check("midrst_hilo", {hi, lo},      64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      do_op("multu_small", 2'b01, 32'd3, 32'd5, 64'h0000_0000_0000_000F, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
